// File: rtl/states_bank_pkg.sv
// Shared encodings and saturation bounds for the neuron state bank.
// latency: n/a; backpressure: n/a.
package states_bank_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_LOAD = 2'b10,
        MODE_NOP  = 2'b11
    } upd_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } dump_fsm_e;

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/state_sat_alu.sv
// One channel's add/sub/load with clamp to the signed STATE_W range.
// latency: combinational; backpressure: none.
module state_sat_alu
    import states_bank_pkg::*;
#(
    parameter int STATE_W  = 16,
    parameter int WEIGHT_W = 8
) (
    input  logic [1:0]                mode,
    input  logic signed [STATE_W-1:0]  state,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic signed [STATE_W-1:0]  result,
    output logic                       sat
);

    localparam logic signed [STATE_W:0] HI = (STATE_W+1)'(sat_max(STATE_W));
    localparam logic signed [STATE_W:0] LO = (STATE_W+1)'(sat_min(STATE_W));

    logic signed [STATE_W:0] wext;
    logic signed [STATE_W:0] sext;
    logic signed [STATE_W:0] sum;

    assign wext = {{(STATE_W + 1 - WEIGHT_W){weight[WEIGHT_W-1]}}, weight};
    assign sext = {state[STATE_W-1], state};

    always_comb begin
        sum    = '0;
        result = state;
        sat    = 1'b0;
        case (mode)
            MODE_ADD:  sum = sext + wext;
            MODE_SUB:  sum = sext - wext;
            default:   sum = sext;
        endcase
        case (mode)
            MODE_ADD, MODE_SUB: begin
                // One extra bit of headroom makes overflow a plain range test.
                if (sum > HI) begin
                    result = HI[STATE_W-1:0];
                    sat    = 1'b1;
                end else if (sum < LO) begin
                    result = LO[STATE_W-1:0];
                    sat    = 1'b1;
                end else begin
                    result = sum[STATE_W-1:0];
                end
            end
            MODE_LOAD: result = wext[STATE_W-1:0];
            default:   result = state;
        endcase
    end

endmodule

// File: rtl/states_bank_sat.sv
// Saturating neuron state bank with masked parallel update, registered read port and snapshot dump.
// latency: update visible on rd_data 1 cycle later; backpressure: dump stalls on dump_ready, updates refused while dumping.
module states_bank_sat
    import states_bank_pkg::*;
#(
    parameter int NUM_CH   = 10,
    parameter int STATE_W  = 16,
    parameter int WEIGHT_W = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                clear,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [NUM_CH-1:0]   upd_mask,
    input  logic [WEIGHT_W-1:0] upd_weight,
    input  logic [1:0]          upd_mode,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [STATE_W-1:0]  rd_data,
    input  logic                dump_start,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [STATE_W-1:0]  dump_data,
    output logic [ADDR_W-1:0]   dump_idx,
    output logic                dump_last,
    output logic                busy,
    output logic                sat_flag
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CH - 1);

    logic [STATE_W-1:0] st      [NUM_CH];
    logic [STATE_W-1:0] alu_res [NUM_CH];
    logic [NUM_CH-1:0]  alu_sat;
    dump_fsm_e          fsm;
    logic               upd_fire;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_alu
        state_sat_alu #(
            .STATE_W  (STATE_W),
            .WEIGHT_W (WEIGHT_W)
        ) u_alu (
            .mode   (upd_mode),
            .state  (st[g]),
            .weight (upd_weight),
            .result (alu_res[g]),
            .sat    (alu_sat[g])
        );
    end

    assign upd_ready  = (fsm == ST_IDLE);
    assign busy       = (fsm == ST_DUMP);
    assign dump_valid = busy;
    assign upd_fire   = upd_valid & upd_ready;
    assign dump_data  = st[dump_idx];
    assign dump_last  = (dump_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_CH; i++) st[i] <= '0;
            sat_flag <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_data <= (rd_addr <= LAST_IDX) ? st[rd_addr] : '0;
            if (clear) begin
                for (int i = 0; i < NUM_CH; i++) st[i] <= '0;
                sat_flag <= 1'b0;
            end else if (upd_fire) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (upd_mask[i]) st[i] <= alu_res[i];
                end
                sat_flag <= sat_flag | (|(alu_sat & upd_mask));
            end
        end
    end

    // Updates are refused in DUMP, so the states read out form a coherent snapshot.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            fsm      <= ST_IDLE;
            dump_idx <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    dump_idx <= '0;
                    if (dump_start && !clear) fsm <= ST_DUMP;
                end
                ST_DUMP: begin
                    if (clear) begin
                        fsm      <= ST_IDLE;
                        dump_idx <= '0;
                    end else if (dump_ready) begin
                        if (dump_last) begin
                            fsm      <= ST_IDLE;
                            dump_idx <= '0;
                        end else begin
                            dump_idx <= dump_idx + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    fsm      <= ST_IDLE;
                    dump_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_states_bank_sat.sv
// Bench for states_bank_sat: vector table, directed corner sequences and a randomized run against a model.
module tb_states_bank_sat;

    localparam int NUM_CH = 10;

    logic        clk, rst_l, clear, upd_valid, upd_ready;
    logic [9:0]  upd_mask;
    logic [7:0]  upd_weight;
    logic [1:0]  upd_mode;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        dump_start, dump_valid, dump_ready;
    logic [15:0] dump_data;
    logic [3:0]  dump_idx;
    logic        dump_last, busy, sat_flag;

    int total = 0;
    int bad   = 0;
    int model [NUM_CH];
    bit msat;

    typedef struct {
        int mask;
        int mode;
        int w;
        int exp5;
        int exp_sat;
    } vec_t;
    vec_t vt [9];

    states_bank_sat #(.NUM_CH(10), .STATE_W(16), .WEIGHT_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_l(rst_l), .clear(clear),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_mask(upd_mask),
        .upd_weight(upd_weight), .upd_mode(upd_mode),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_idx(dump_idx), .dump_last(dump_last),
        .busy(busy), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) model[i] = 0;
        msat = 1'b0;
    endtask

    // Reference arithmetic: plain integers, clamped to the 16-bit signed range.
    task automatic model_upd(input int mask, input int w, input int mode);
        int r;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
                case (mode)
                    0: r = model[i] + w;
                    1: r = model[i] - w;
                    2: r = w;
                    default: r = model[i];
                endcase
                if (r > 32767) begin r = 32767; msat = 1'b1; end
                if (r < -32768) begin r = -32768; msat = 1'b1; end
                model[i] = r;
            end
        end
    endtask

    task automatic upd(input int mask, input int w, input int mode);
        upd_valid  = 1'b1;
        upd_mask   = 10'(mask);
        upd_weight = 8'(w);
        upd_mode   = 2'(mode);
        tick();
        upd_valid  = 1'b0;
        model_upd(mask, w, mode);
    endtask

    task automatic rd_chk(input string name, input int ch, input int exp);
        int v;
        rd_addr = 4'(ch);
        tick();
        v = $signed(rd_data);
        chk(name, v, exp);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
    endtask

    initial begin
        int beats, v, exp_rd, a, m, w, md;
        bit found, vld, clr;

        rst_l = 1'b0; clear = 1'b0; upd_valid = 1'b0; upd_mask = '0; upd_weight = '0;
        upd_mode = '0; rd_addr = '0; dump_start = 1'b0; dump_ready = 1'b0;
        model_clear();

        vt[0] = '{32'h020, 2,  100,  100, 0};
        vt[1] = '{32'h020, 0,  -28,   72, 0};
        vt[2] = '{32'h020, 1,  -50,  122, 0};
        vt[3] = '{32'h020, 1,  127,   -5, 0};
        vt[4] = '{32'h020, 3,   99,   -5, 0};
        vt[5] = '{32'h020, 2, -128, -128, 0};
        vt[6] = '{32'h020, 1, -128,    0, 0};
        vt[7] = '{32'h010, 0,   50,    0, 0};
        vt[8] = '{32'h030, 2,  -77,  -77, 0};

        // Reset values while reset is held.
        #12;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_dump_idx", dump_idx, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd_ready", upd_ready, 1);
        @(negedge clk);
        rst_l = 1'b1;

        // 1: basic add on a mask.
        upd(32'h005, 3, 0);
        upd(32'h005, 3, 0);
        rd_chk("t1_ch0", 0, 6);
        rd_chk("t1_ch2", 2, 6);
        rd_chk("t1_ch1", 1, 0);
        chk("t1_sat", sat_flag, 0);

        // 2: positive saturation on the 259th add.
        do_clear();
        for (int k = 0; k < 258; k++) upd(32'h001, 127, 0);
        rd_chk("t2_ch0_258", 0, 32766);
        chk("t2_sat_258", sat_flag, 0);
        upd(32'h001, 127, 0);
        rd_chk("t2_ch0_259", 0, 32767);
        chk("t2_sat_259", sat_flag, 1);

        // 3: negative bound reached exactly at 256, clamp on 257.
        do_clear();
        chk("t3_sat_cleared", sat_flag, 0);
        for (int k = 0; k < 256; k++) upd(32'h002, -128, 0);
        chk("t3_sat_256", sat_flag, 0);
        rd_chk("t3_ch1_256", 1, -32768);
        upd(32'h002, -128, 0);
        chk("t3_sat_257", sat_flag, 1);
        rd_chk("t3_ch1_257", 1, -32768);

        // Vector table on channel 5.
        do_clear();
        for (int i = 0; i < 9; i++) begin
            upd(vt[i].mask, vt[i].w, vt[i].mode);
            rd_chk($sformatf("vec%0d_ch5", i), 5, vt[i].exp5);
            chk($sformatf("vec%0d_sat", i), sat_flag, vt[i].exp_sat);
        end
        rd_chk("vec_ch4", 4, -77);

        // Randomized run against the model, idle side only.
        for (int c = 0; c < 400; c++) begin
            vld = 1'($urandom_range(0, 1));
            m   = $urandom_range(0, 1023);
            w   = $urandom_range(0, 255) - 128;
            md  = $urandom_range(0, 3);
            a   = $urandom_range(0, 15);
            clr = ($urandom_range(0, 31) == 0);
            exp_rd = (a < NUM_CH) ? model[a] : 0;
            upd_valid = vld; upd_mask = 10'(m); upd_weight = 8'(w);
            upd_mode = 2'(md); rd_addr = 4'(a); clear = clr;
            tick();
            if (clr) model_clear();
            else if (vld) model_upd(m, w, md);
            v = $signed(rd_data);
            chk("rand_rd", v, exp_rd);
            chk("rand_sat", sat_flag, msat);
        end
        upd_valid = 1'b0; clear = 1'b0;

        // 4: dump with toggling ready while an update is held off.
        do_clear();
        for (int i = 0; i < NUM_CH; i++) upd(1 << i, i, 2);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("t4_busy", busy, 1);
        chk("t4_first_idx", dump_idx, 0);
        upd_valid = 1'b1; upd_mask = 10'h3FF; upd_weight = 8'd1; upd_mode = 2'd0;
        beats = 0;
        for (int cyc = 0; cyc < 60 && beats < 10; cyc++) begin
            dump_ready = cyc[0];
            chk("t4_upd_ready", upd_ready, 0);
            chk("t4_valid", dump_valid, 1);
            chk("t4_idx", dump_idx, beats);
            chk("t4_data", dump_data, beats);
            if (dump_ready) begin
                chk("t4_last", dump_last, (beats == 9) ? 1 : 0);
                beats++;
            end
            tick();
        end
        chk("t4_beats", beats, 10);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_ready", upd_ready, 1);
        dump_ready = 1'b0;
        tick();
        upd_valid = 1'b0;
        model_upd(32'h3FF, 1, 0);
        rd_chk("t4_after_ch4", 4, 5);
        rd_chk("t4_after_ch9", 9, 10);

        // 5: clear aborts a dump at beat 4.
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (dump_valid && dump_idx == 4'd4) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_reached_beat4", found, 1);
        do_clear();
        chk("t5_valid", dump_valid, 0);
        chk("t5_busy", busy, 0);
        for (int i = 0; i < NUM_CH; i++) rd_chk($sformatf("t5_rd%0d", i), i, 0);
        chk("t5_sat", sat_flag, 0);

        // 6: async reset in the middle of a dump, with sat_flag and rd_data nonzero.
        for (int k = 0; k < 257; k++) upd(32'h002, -128, 0);
        upd(32'h001, 77, 2);
        rd_chk("t6_pre_rd", 0, 77);
        chk("t6_pre_sat", sat_flag, 1);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        tick();
        chk("t6_pre_idx", dump_idx, 2);
        #3;
        rst_l = 1'b0;
        #1;
        chk("t6_valid", dump_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_idx", dump_idx, 0);
        chk("t6_rd", rd_data, 0);
        chk("t6_sat", sat_flag, 0);
        dump_ready = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        model_clear();
        rd_chk("t6_rd12", 12, 0);
        rd_chk("t6_rd0", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
